// File: rtl/level_disp_pkg.sv
// Shared types and glyph constants for the level display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package level_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_e;

    localparam int LEVEL_MAX_DEFAULT = 100;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock after start_i.
// bcd_o is valid only in the cycle done_o is high (the final step).
module bin2bcd_seq
    import level_disp_pkg::*;
#(
    parameter int SHIFT_STEPS = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [SHIFT_STEPS-1:0] bin_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [11:0]            bcd_o
);

    localparam int SR_W   = 12 + SHIFT_STEPS;
    localparam int STEP_W = (SHIFT_STEPS > 1) ? $clog2(SHIFT_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SHIFT_STEPS - 1);

    conv_state_e       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [SR_W-1:0]   shreg_q, shreg_d;
    logic [SR_W-1:0]   adj, shifted;

    always_comb begin
        adj = shreg_q;
        for (int n = 0; n < 3; n++) begin
            if (adj[SHIFT_STEPS + 4*n +: 4] >= 4'd5)
                adj[SHIFT_STEPS + 4*n +: 4] = adj[SHIFT_STEPS + 4*n +: 4] + 4'd3;
        end
        shifted = {adj[SR_W-2:0], 1'b0};
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        shreg_d = shreg_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = {12'd0, bin_i};
                    step_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shreg_d = shifted;
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bcd_o  = shifted[SR_W-1 -: 12];
    assign busy_o = (state_q == CONV);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            step_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/level_display_driver.sv
// Samples the level once per second, converts it to BCD and drives a
// multiplexed 4-digit active-low 7-segment display with alarm blinking.
module level_display_driver
    import level_disp_pkg::*;
#(
    parameter int LEVEL_MAX   = LEVEL_MAX_DEFAULT,
    parameter int SHIFT_STEPS = 7
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   tick_1kHz,
    input  logic                   tick_1Hz,
    input  logic [SHIFT_STEPS-1:0] level,
    input  logic                   alarm,
    output logic [3:0]             an,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic                   busy
);

    localparam logic [SHIFT_STEPS-1:0] LEVEL_CAP = SHIFT_STEPS'(LEVEL_MAX);

    logic [SHIFT_STEPS-1:0] level_sat;
    logic                   conv_start, conv_done;
    logic [11:0]            conv_bcd;
    logic [11:0]            disp_q, disp_d;
    logic [1:0]             idx_q, idx_d;
    logic                   blink_q, blink_d;
    logic [3:0]             an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic [3:0]             hund, tens, ones;

    assign level_sat  = (level > LEVEL_CAP) ? LEVEL_CAP : level;
    assign conv_start = tick_1Hz && !busy;

    bin2bcd_seq #(
        .SHIFT_STEPS(SHIFT_STEPS)
    ) u_bin2bcd (
        .clk_i  (clk_100MHz),
        .rst_i  (reset),
        .start_i(conv_start),
        .bin_i  (level_sat),
        .busy_o (busy),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    assign {hund, tens, ones} = disp_q;

    always_comb begin
        disp_d  = conv_done ? conv_bcd : disp_q;
        idx_d   = tick_1kHz ? idx_q + 2'd1 : idx_q;
        blink_d = alarm ? (blink_q ^ tick_1Hz) : 1'b1;
        an_d    = blink_q ? ~(4'b0001 << idx_q) : 4'b1111;
        case (idx_q)
            2'd0:    seg_d = digit_glyph(ones);
            2'd1:    seg_d = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_glyph(tens);
            2'd2:    seg_d = (hund == 4'd0) ? SEG_BLANK : digit_glyph(hund);
            default: seg_d = SEG_L;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            disp_q  <= '0;
            idx_q   <= '0;
            blink_q <= 1'b1;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            disp_q  <= disp_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_level_display_driver.sv
// Self-checking bench: directed scenarios followed by random stimulus, all
// compared every cycle against a behavioural model of the display.
module tb_level_display_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1kHz = 1'b0;
    logic       tick_1Hz = 1'b0;
    logic [6:0] level = 7'd0;
    logic       alarm = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int         m_disp = 0;
    int         m_pend = 0;
    int         m_left = 0;
    int         m_idx = 0;
    bit         m_blink = 1'b1;
    logic [3:0] m_an = 4'b1111;
    logic [6:0] m_seg = 7'h7F;

    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    level_display_driver dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .tick_1kHz (tick_1kHz),
        .tick_1Hz  (tick_1Hz),
        .level     (level),
        .alarm     (alarm),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] view(input int idx, input int v);
        case (idx)
            0:       return glyph[v % 10];
            1:       return (v < 10) ? 7'h7F : glyph[(v / 10) % 10];
            2:       return (v < 100) ? 7'h7F : glyph[v / 100];
            default: return 7'b1000111;
        endcase
    endfunction

    // One clock: inputs are stable across the edge; model advances, then outputs are compared.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            m_an = 4'b1111; m_seg = 7'h7F;
            m_disp = 0; m_left = 0; m_idx = 0; m_blink = 1'b1;
        end else begin
            m_an  = m_blink ? ~(4'(1) << m_idx) : 4'b1111;
            m_seg = view(m_idx, m_disp);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_disp = m_pend;
            end else if (tick_1Hz) begin
                m_pend = (int'(level) > 100) ? 100 : int'(level);
                m_left = 7;
            end
            if (tick_1kHz) m_idx = (m_idx + 1) % 4;
            m_blink = alarm ? (m_blink ^ tick_1Hz) : 1'b1;
        end
        check("an", 32'(an), 32'(m_an));
        check("seg", 32'(seg), 32'(m_seg));
        check("dp", 32'(dp), 32'd1);
        check("busy", 32'(busy), 32'(m_left != 0));
    endtask

    task automatic pulse_1hz();
        tick_1Hz = 1'b1; step(); tick_1Hz = 1'b0;
    endtask

    task automatic scan_all();
        for (int i = 0; i < 4; i++) begin
            tick_1kHz = 1'b1; step(); tick_1kHz = 1'b0; step(); step();
        end
    endtask

    initial begin
        reset = 1'b1; step(); step();
        reset = 1'b0; step();
        tick_1kHz = 1'b1; step(); tick_1kHz = 1'b0; step(); step();
        scan_all();

        level = 7'd57; pulse_1hz();
        level = 7'd3;
        for (int i = 0; i < 9; i++) step();
        scan_all();

        level = 7'd120; pulse_1hz();
        for (int i = 0; i < 9; i++) step();
        scan_all();

        alarm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_1hz(); step(); tick_1kHz = 1'b1; step(); tick_1kHz = 1'b0;
            for (int k = 0; k < 8; k++) step();
        end
        alarm = 1'b0; step(); step(); step();

        level = 7'd42; pulse_1hz(); step(); step();
        level = 7'd9;  pulse_1hz();
        for (int i = 0; i < 8; i++) step();
        scan_all();

        level = 7'd88; pulse_1hz(); step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0; step(); step();
        scan_all();

        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 399) == 0);
            tick_1kHz = ($urandom_range(0, 2) == 0);
            tick_1Hz  = ($urandom_range(0, 11) == 0);
            level     = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 59) == 0) alarm = ~alarm;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
